arb_mux_reg: RTL
================

# arb_mux_reg

Parametrised, registered N:1 datapath multiplexer with valid/ready handshaking on every input and on the output. It is the pipelined successor to the combinational 16-bit 8:1 select muxes. The source is chosen either by an external select (MODE 0) or by an internal round-robin arbiter (MODE 1). It sits between pipeline stages wherever several producers feed one consumer, e.g. writeback-source selection or shared-port arbitration. It provides one register stage and full single-cycle throughput.

## Interface
- WIDTH, 16: data width per channel, ≥1.
- N, 8: number of input channels, ≥2; non-power-of-two allowed.
- MODE, 0: 0 = external select, 1 = round-robin arbitration.
- SELW, derived: max(1, clog2(N)); not overridden by users.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i offers a word.
- in_ready  out  N  channel i word is accepted this cycle.
- sel  in  SELW  channel select; used in MODE 0, ignored in MODE 1.
- out_data  out  WIDTH  registered selected word.
- out_src  out  SELW  index of the channel that supplied out_data.
- out_valid  out  1  out_data/out_src hold a word.
- out_ready  in  1  consumer accepts the word this cycle.

## Operation
- load_en = !out_valid | out_ready. The output register may load when it is empty or is being drained in the same cycle.
- Candidate selection, MODE 0: cand = sel; there is a request only if sel < N and in_valid[sel]. If sel ≥ N, no channel is granted.
- Candidate selection, MODE 1: cand = the first i with in_valid[i], scanning ptr, ptr+1, … N-1, 0, … ptr-1. There is a request if any in_valid bit is set.
- in_ready[i] = load_en & request & (i == cand). At most one bit is high. in_ready may depend combinationally on in_valid, sel and out_ready.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= channel i data
  - out_src <= i
  - out_valid <= 1
- Drain without a new transfer (out_valid & out_ready & no request): out_valid <= 0. out_data and out_src keep their last values.
- Stall (out_valid & !out_ready): out_data, out_src and out_valid hold. All in_ready bits are 0.
- Round-robin pointer ptr (SELW bits, MODE 1 only):
  - After a transfer from channel c, ptr <= c+1, wrapping to 0 when c = N-1.
  - ptr never holds a value ≥ N.
  - ptr is unchanged when there is no transfer.
- MODE 0 has no pointer state. Implementations may optimise it away.
- Reset, which overrides everything including a simultaneous transfer:
  - out_valid=0, out_data=0, out_src=0, ptr=0.
  - in_ready is all 0 during the reset cycle.

## Timing
- Latency: 1 cycle from input handshake to out_valid/out_data.
- Throughput: 1 word per cycle with out_ready held high, including back-to-back words from different channels.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1, with no bubble.
- Outputs are driven only from registers, except in_ready, which is combinational.
- Reset mid-stream: the word in the register is discarded. The first transfer can happen on the first cycle after rst deasserts.

## Test plan
- Reset: assert rst with out_ready=0 and all in_valid=1 -> next cycle out_valid=0, out_data=0, out_src=0, in_ready=0. After release in MODE 1, the first grant is channel 0.
- MODE 0 select: sel=3, in_valid=8'h08, channel 3 data 16'hBEEF -> in_ready=8'h08; next cycle out_data=16'hBEEF, out_src=3, out_valid=1. With sel=3 and in_valid=8'h04 -> no grant, out_valid drops after the drain.
- Backpressure: out_valid=1 holding 16'h1234, out_ready=0 for 3 cycles while channel 0 is valid -> out_data stays 16'h1234 and in_ready=0 throughout. Raising out_ready -> channel 0 word is loaded the same cycle, with no bubble.
- Round-robin fairness: MODE 1, N=8, all in_valid=1, out_ready=1 -> out_src sequence 0,1,…,7,0,1 on consecutive cycles. With in_valid=8'b0010_0100 -> sequence 2,5,2,5.
- Non-power-of-two wrap: MODE 1, N=5, only channel 4 valid then only channel 0 valid -> after the grant to 4, ptr=0 and the next grant is 0. ptr never exceeds 4.
- Out-of-range select and reset mid-operation: MODE 0, N=5, sel=6 -> in_ready=0 and no transfer. Asserting rst while out_valid=1 and a transfer is pending -> the next cycle shows out_valid=0 and the pending word is never emitted.

Source files
------------

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: registered N:1 mux with valid/ready on every channel.
// The source is picked by an external select (MODE 0) or by a round-robin
// arbiter (MODE 1). There is one output register stage and the block
// sustains one word per cycle.
module arb_mux_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int MODE  = 0,
    localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             load_en;
    logic             req;
    logic             xfer;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  ptr;
    logic [WIDTH-1:0] cand_data;

    // Candidate channel and request flag. MODE 1 scans from ptr upward with
    // wrap; the scan runs backwards so the nearest valid channel wins last.
    always_comb begin
        int idx;
        cand = '0;
        req  = 1'b0;
        idx  = 0;
        if (MODE == 0) begin
            cand = sel;
            for (int i = 0; i < N; i++)
                if (sel == SELW'(i) && in_valid[i]) req = 1'b1;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (in_valid[idx]) begin
                    cand = SELW'(idx);
                    req  = 1'b1;
                end
            end
        end
    end

    // Data of the candidate channel. An out-of-range sel yields zero, but it
    // never loads because req is low in that case.
    always_comb begin
        cand_data = '0;
        for (int i = 0; i < N; i++)
            if (cand == SELW'(i)) cand_data = in_data[i*WIDTH +: WIDTH];
    end

    // Handshake: load when empty or draining; reset blocks all grants.
    always_comb begin
        load_en = !out_valid || out_ready;
        xfer    = load_en && req && !rst;
        for (int i = 0; i < N; i++)
            in_ready[i] = xfer && (cand == SELW'(i));
    end

    // Output register: load on transfer, clear valid on a bare drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= cand_data;
            out_src   <= cand;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer: one past the last granted channel, wrapping at N.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (MODE == 1 && xfer)
            ptr <= (int'(cand) == N - 1) ? '0 : cand + 1'b1;
    end

endmodule
